// File: rtl/aes_pkg.sv
// aes_pkg: shared state encoding and block geometry for the AES block loader
package aes_pkg;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W = 128;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_HOLD} state_t;
endpackage

// File: rtl/aes_word_packer.sv
// aes_word_packer: 32->128 shift packer, first word lands in [127:96]
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : sync clear of the word count (block contents kept)
//   i_wr           : shift i_data in this cycle
//   o_block        : packed block
//   o_cnt, o_full  : words held, full when all four are present
//   WRAP           : count returns to 0 after the last word instead of holding at full
module aes_word_packer
  import aes_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_wr,
  input  logic [WORD_W-1:0]  i_data,
  output logic [BLOCK_W-1:0] o_block,
  output logic [2:0]         o_cnt,
  output logic               o_full
);
  logic [BLOCK_W-1:0] r_block;
  logic [2:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_block <= '0;
      r_cnt <= '0;
    end else begin
      if (i_wr) r_block <= {r_block[BLOCK_W-WORD_W-1:0], i_data};
      if (i_clr) r_cnt <= '0;
      else if (i_wr) r_cnt <= (WRAP && r_cnt == 3'(WORDS_PER_BLOCK - 1)) ? 3'd0 : r_cnt + 3'd1;
    end
  end
  assign o_block = r_block;
  assign o_cnt = r_cnt;
  assign o_full = r_cnt == 3'(WORDS_PER_BLOCK);
endmodule

// File: rtl/aes_block_loader.sv
// aes_block_loader: gathers host words into key/plaintext, runs AES_top with a watchdog
//   AES_clk, AES_rst_n          : clock, async active-low reset
//   wr_valid/wr_ready/wr_data   : host word handshake, wr_is_key selects key or data group
//   soft_clr                    : sync clear of counters, key_loaded, timeout_err; back to FILL
//   AES_en/AES_data_in/AES_key_in : drive to AES_top, stable for the whole RUN state
//   AES_data_out_valid          : completion from AES_top
//   busy, done, timeout_err     : RUN/HOLD flag, normal-completion pulse, sticky abort flag
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic                AES_clk,
  input  logic                AES_rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                wr_is_key,
  input  logic                soft_clr,
  output logic                AES_en,
  output logic [BLOCK_W-1:0]  AES_data_in,
  output logic [BLOCK_W-1:0]  AES_key_in,
  input  logic                AES_data_out_valid,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);
  state_t r_state, w_state_nxt;
  logic r_key_loaded, r_done, r_timeout_err;
  logic [CNT_W-1:0] r_wd;
  logic [2:0] w_key_cnt, w_data_cnt;
  logic w_key_full, w_data_full, w_accept, w_key_wr, w_data_wr;
  logic w_key_loaded_nxt, w_start, w_wd_exp, w_run;
  assign w_run = r_state == ST_RUN;
  assign wr_ready = r_state == ST_FILL && (wr_is_key ? !w_key_full : !w_data_full);
  assign w_accept = wr_valid & wr_ready & ~soft_clr;
  assign w_key_wr = w_accept & wr_is_key;
  assign w_data_wr = w_accept & ~wr_is_key;
  aes_word_packer #(.WRAP(1'b1)) u_key (
    .i_clk(AES_clk), .i_rst_n(AES_rst_n), .i_clr(soft_clr), .i_wr(w_key_wr),
    .i_data(wr_data), .o_block(AES_key_in), .o_cnt(w_key_cnt), .o_full(w_key_full)
  );
  aes_word_packer #(.WRAP(1'b0)) u_data (
    .i_clk(AES_clk), .i_rst_n(AES_rst_n), .i_clr(soft_clr | r_state == ST_HOLD), .i_wr(w_data_wr),
    .i_data(wr_data), .o_block(AES_data_in), .o_cnt(w_data_cnt), .o_full(w_data_full)
  );
  // Start decision looks at the counts after this cycle's write so RUN follows the last word by one cycle
  assign w_key_loaded_nxt = (w_key_wr && w_key_cnt == 3'(WORDS_PER_BLOCK - 1)) ||
                            (r_key_loaded && !(w_key_wr && w_key_cnt == 3'd0));
  assign w_start = (w_data_full || (w_data_wr && w_data_cnt == 3'(WORDS_PER_BLOCK - 1))) &&
                   w_key_loaded_nxt && (w_key_wr ? w_key_cnt == 3'(WORDS_PER_BLOCK - 1) : w_key_cnt == 3'd0);
  assign w_wd_exp = r_wd == CNT_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    w_state_nxt = ST_FILL;
    case (r_state)
      ST_FILL: w_state_nxt = w_start ? ST_RUN : ST_FILL;
      ST_RUN:  w_state_nxt = (AES_data_out_valid | w_wd_exp) ? ST_HOLD : ST_RUN;
      default: w_state_nxt = ST_FILL;
    endcase
    if (soft_clr) w_state_nxt = ST_FILL;
  end
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_state <= ST_FILL;
      r_key_loaded <= 1'b0;
      r_wd <= '0;
      r_done <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key_loaded <= !soft_clr && w_key_loaded_nxt;
      r_wd <= (w_run && !soft_clr) ? r_wd + CNT_W'(1) : '0;
      r_done <= !soft_clr && w_run && AES_data_out_valid;
      // valid wins over an expiring watchdog in the same cycle
      r_timeout_err <= !soft_clr && (r_timeout_err || (w_run && !AES_data_out_valid && w_wd_exp));
    end
  end
  assign AES_en = w_run;
  assign busy = w_run || r_state == ST_HOLD;
  assign done = r_done;
  assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: directed stimulus with a scoreboard of expected AES runs
module tb_aes_block_loader;
  logic AES_clk = 1'b0, AES_rst_n = 1'b0, wr_valid = 1'b0, wr_is_key = 1'b0, soft_clr = 1'b0;
  logic AES_data_out_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic wr_ready, AES_en, busy, done, timeout_err;
  logic [127:0] AES_data_in, AES_key_in;
  typedef struct {logic [127:0] k; logic [127:0] d; logic dn; logic to; int len;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int n_cmp = 0, n_err = 0, run_len = 0;
  logic prev_en = 1'b0, have = 1'b0;
  localparam logic [127:0] K1 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] K2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] D1 = 128'h000000fd_00000000_00000000_00000000;
  localparam logic [127:0] D3 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
  localparam logic [127:0] D4 = 128'hf301a68a_11223344_55667788_99aabbcc;
  localparam logic [127:0] D5 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] D6 = 128'h0badf00d_cafebabe_12345678_9abcdef0;
  localparam logic [127:0] D7 = 128'h01010101_02020202_03030303_04040404;
  localparam logic [127:0] D8 = 128'hfeedface_c0ffee00_31415926_27182818;
  localparam logic [127:0] D9 = 128'h13579bdf_2468ace0_0f0f0f0f_f0f0f0f0;

  aes_block_loader dut (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_is_key(wr_is_key), .soft_clr(soft_clr), .AES_en(AES_en),
    .AES_data_in(AES_data_in), .AES_key_in(AES_key_in), .AES_data_out_valid(AES_data_out_valid),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 AES_clk = ~AES_clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] w, input logic k);
    wr_valid = 1'b1;
    wr_data = w;
    wr_is_key = k;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wr_blk(input logic [127:0] b, input logic k, input int n);
    for (int i = 0; i < n; i++) wr(b[127-32*i -: 32], k);
  endtask

  task automatic push(input logic [127:0] k, input logic [127:0] d, input logic dn, input logic to, input int len);
    exp_t e;
    e.k = k; e.d = d; e.dn = dn; e.to = to; e.len = len;
    sb.push_back(e);
  endtask

  task automatic finish_block(input int n);
    repeat (n - 1) tick();
    AES_data_out_valid = 1'b1;
    tick();
    AES_data_out_valid = 1'b0;
  endtask

  always @(negedge AES_clk) begin
    if (AES_en && !prev_en) begin
      if (sb.size() == 0) chk("unexpected_run", 1'b1, 1'b0);
      else begin
        cur = sb.pop_front();
        have = 1'b1;
        run_len = 0;
      end
    end
    if (AES_en && have) begin
      chk("run_key", AES_key_in, cur.k);
      chk("run_data", AES_data_in, cur.d);
      run_len++;
    end
    if (!AES_en && prev_en && have) begin
      chk("end_done", done, cur.dn);
      chk("end_timeout", timeout_err, cur.to);
      if (cur.len != 0) chk("run_len", run_len, cur.len);
      have = 1'b0;
    end
    prev_en = AES_en;
  end

  initial begin
    #30 AES_rst_n = 1'b1;
    tick();
    chk("rst_en", AES_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_key", AES_key_in, 0);
    chk("rst_data", AES_data_in, 0);
    wr_is_key = 1'b1;
    #1 chk("rst_rdy_key", wr_ready, 1);
    wr_is_key = 1'b0;
    #1 chk("rst_rdy_data", wr_ready, 1);
    tick();
    // basic block
    wr_blk(K1, 1'b1, 4);
    wr_blk(D1, 1'b0, 3);
    chk("basic_no_en_early", AES_en, 0);
    push(K1, D1, 1'b1, 1'b0, 3);
    wr(32'h0, 1'b0);
    chk("basic_en_rise", AES_en, 1);
    chk("basic_busy", busy, 1);
    finish_block(3);
    chk("basic_done", done, 1);
    chk("basic_hold_busy", busy, 1);
    chk("basic_hold_en", AES_en, 0);
    tick();
    chk("basic_done_once", done, 0);
    chk("basic_fill_busy", busy, 0);
    // data before key, stall, then key reuse
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    wr_blk(D3, 1'b0, 4);
    chk("nokey_no_en", AES_en, 0);
    wr_valid = 1'b1; wr_is_key = 1'b0; wr_data = 32'hd7b26248;
    #1 chk("stall_rdy", wr_ready, 0);
    tick();
    wr_valid = 1'b0;
    wr_is_key = 1'b1;
    #1 chk("stall_key_rdy", wr_ready, 1);
    wr_blk(K2, 1'b1, 3);
    push(K2, D3, 1'b1, 1'b0, 2);
    wr(K2[31:0], 1'b1);
    chk("key_en_rise", AES_en, 1);
    finish_block(2);
    tick();
    wr_blk(D4, 1'b0, 3);
    push(K2, D4, 1'b1, 1'b0, 5);
    wr(D4[31:0], 1'b0);
    chk("reuse_en_rise", AES_en, 1);
    finish_block(5);
    tick();
    // watchdog
    wr_blk(D5, 1'b0, 3);
    push(K2, D5, 1'b0, 1'b1, 64);
    wr(D5[31:0], 1'b0);
    for (int i = 0; i < 100 && AES_en; i++) tick();
    chk("wd_ended", AES_en, 0);
    chk("wd_err", timeout_err, 1);
    chk("wd_no_done", done, 0);
    chk("wd_hold_busy", busy, 1);
    tick();
    wr_is_key = 1'b0;
    #1 chk("wd_fill_rdy", wr_ready, 1);
    chk("wd_sticky", timeout_err, 1);
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    chk("wd_clr", timeout_err, 0);
    // valid on the final watchdog cycle
    wr_blk(K1, 1'b1, 4);
    wr_blk(D6, 1'b0, 3);
    push(K1, D6, 1'b1, 1'b0, 64);
    wr(D6[31:0], 1'b0);
    finish_block(64);
    chk("race_done", done, 1);
    chk("race_no_err", timeout_err, 0);
    tick();
    // async reset mid-run
    wr_blk(D7, 1'b0, 3);
    push(K1, D7, 1'b0, 1'b0, 0);
    wr(D7[31:0], 1'b0);
    chk("arst_run", AES_en, 1);
    repeat (5) tick();
    AES_rst_n = 1'b0;
    #1 chk("arst_en", AES_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_key", AES_key_in, 0);
    chk("arst_data", AES_data_in, 0);
    #2 AES_rst_n = 1'b1;
    tick();
    // soft_clr mid-run with a simultaneous write
    wr_blk(K2, 1'b1, 4);
    wr_blk(D8, 1'b0, 3);
    push(K2, D8, 1'b0, 1'b0, 0);
    wr(D8[31:0], 1'b0);
    repeat (3) tick();
    soft_clr = 1'b1; wr_valid = 1'b1; wr_is_key = 1'b0; wr_data = 32'hdeadbeef;
    tick();
    soft_clr = 1'b0; wr_valid = 1'b0;
    chk("sclr_en", AES_en, 0);
    chk("sclr_busy", busy, 0);
    chk("sclr_data_kept", AES_data_in, D8);
    chk("sclr_key_kept", AES_key_in, K2);
    #1 chk("sclr_rdy", wr_ready, 1);
    wr_blk(K1, 1'b1, 4);
    wr_blk(D9, 1'b0, 3);
    chk("sclr_cnt_zero", AES_en, 0);
    push(K1, D9, 1'b1, 1'b0, 2);
    wr(D9[31:0], 1'b0);
    chk("sclr_restart", AES_en, 1);
    finish_block(2);
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
